// File: rtl/seq_shifter_if.sv
// ============================================================================
// Module  : seq_shifter_if
// Brief   : Command/result handshake bundle for the sequential shifter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             dir;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             busy;

    modport master (
        output in_valid, a, dir, mode, amt, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, dir, mode, amt, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

`default_nettype wire

// File: rtl/seq_shifter.sv
// ============================================================================
// Module  : seq_shifter
// Brief   : Multi-cycle logical/arithmetic/rotate shifter, STEP bits per clock,
//           valid/ready on command and result, one operation in flight.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  wire          clk,
    input  wire          rst_n,
    seq_shifter_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [AMT_W:0] c_step  = (AMT_W+1)'(STEP);
    localparam logic [AMT_W:0] c_width = (AMT_W+1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_work;
    logic [AMT_W-1:0]   r_rem;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic               r_sign;

    logic               w_accept;
    logic [AMT_W-1:0]   w_step;
    logic [AMT_W:0]     w_inv;
    logic [WIDTH-1:0]   w_shifted;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    // Bits moved this clock: the lesser of STEP and what is still owed.
    always_comb begin
        w_step = r_rem;
        if ({1'b0, r_rem} >= c_step) begin
            w_step = c_step[AMT_W-1:0];
        end
        w_inv = c_width - {1'b0, w_step};
    end

    always_comb begin
        w_shifted = r_work << w_step;
        if (r_mode == 2'b10) begin
            if (r_dir) begin
                w_shifted = (r_work >> w_step) | (r_work << w_inv);
            end else begin
                w_shifted = (r_work << w_step) | (r_work >> w_inv);
            end
        end else if (r_dir) begin
            if (r_mode == 2'b01) begin
                w_shifted = (r_work >> w_step) | ({WIDTH{r_sign}} << w_inv);
            end else begin
                w_shifted = r_work >> w_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (bus.amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_rem == w_step) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_mode <= 2'b00;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_work <= bus.a;
            r_rem  <= bus.amt;
            r_dir  <= bus.dir;
            r_mode <= bus.mode;
            r_sign <= bus.a[WIDTH-1];
        end else if (r_state == S_SHIFT) begin
            r_work <= w_shifted;
            r_rem  <= r_rem - w_step;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.y         = r_work;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// ============================================================================
// Module  : tb_seq_shifter
// Brief   : Scoreboard bench for seq_shifter (8-bit/STEP1 and 16-bit/STEP4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_shifter;
    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8;
    exp_t e16;
    int   acc1;
    int   acc2;
    int   dummy;
    logic [7:0] y_hold;

    seq_shifter_if #(.WIDTH(8))  bus8  ();
    seq_shifter_if #(.WIDTH(16)) bus16 ();

    seq_shifter #(.WIDTH(8),  .STEP(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    seq_shifter #(.WIDTH(16), .STEP(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Issue one command at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit w16, input logic [15:0] a, input logic d, input logic [1:0] m,
                        input logic [3:0] amt, input logic [15:0] ey, input bit push, output int acc);
        bit ok;
        int lat;
        ok = 1'b0;
        if (w16) begin
            bus16.a = a; bus16.dir = d; bus16.mode = m; bus16.amt = amt; bus16.in_valid = 1'b1;
        end else begin
            bus8.a = a[7:0]; bus8.dir = d; bus8.mode = m; bus8.amt = amt[2:0]; bus8.in_valid = 1'b1;
        end
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = w16 ? bus16.in_ready : bus8.in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        bus8.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        acc = cyc;
        lat = w16 ? (int'(amt) + 3) / 4 : int'(amt);
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            if (w16) q16.push_back('{ey, cyc + lat});
            else     q8.push_back('{ey, cyc + lat});
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = !bus8.busy && !bus16.busy && (q8.size() == 0) && (q16.size() == 0);
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin : mon8
        bit prev;
        int vcyc;
        prev = 1'b0;
        vcyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (bus8.out_valid && !prev) vcyc = cyc;
                prev = bus8.out_valid;
                if (bus8.out_valid && bus8.out_ready) begin
                    if (q8.size() == 0) begin
                        chk("unexpected_result8", {24'd0, bus8.y}, 32'hDEAD);
                    end else begin
                        e8 = q8.pop_front();
                        chk("y8", {24'd0, bus8.y}, {16'd0, e8.y});
                        chk("latency8", vcyc, e8.cyc);
                    end
                end
            end
        end
    end

    initial begin : mon16
        bit prev;
        int vcyc;
        prev = 1'b0;
        vcyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (bus16.out_valid && !prev) vcyc = cyc;
                prev = bus16.out_valid;
                if (bus16.out_valid && bus16.out_ready) begin
                    if (q16.size() == 0) begin
                        chk("unexpected_result16", {16'd0, bus16.y}, 32'hDEAD);
                    end else begin
                        e16 = q16.pop_front();
                        chk("y16", {16'd0, bus16.y}, {16'd0, e16.y});
                        chk("latency16", vcyc, e16.cyc);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] lvec [4];
        cyc = 0; n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.dir = 1'b0; bus8.mode = 2'b00; bus8.amt = '0;
        bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.dir = 1'b0; bus16.mode = 2'b00; bus16.amt = '0;
        bus16.out_ready = 1'b1;
        #22;
        chk("rst_y",         {24'd0, bus8.y}, 32'h0);
        chk("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, bus8.busy}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus8.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        lvec[0] = 8'hAC; lvec[1] = 8'h58; lvec[2] = 8'hB0; lvec[3] = 8'h60;
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 16'h00AC, 1'b0, 2'b00, 4'(k), {8'h00, lvec[k]}, 1'b1, dummy);
        end
        wait_idle();

        send(1'b0, 16'h00AC, 1'b1, 2'b00, 4'd3, 16'h0015, 1'b1, dummy);
        send(1'b0, 16'h00AC, 1'b1, 2'b01, 4'd3, 16'h00F5, 1'b1, dummy);
        send(1'b0, 16'h00AC, 1'b1, 2'b10, 4'd3, 16'h0095, 1'b1, dummy);
        send(1'b0, 16'h00AC, 1'b0, 2'b10, 4'd3, 16'h0065, 1'b1, dummy);
        send(1'b0, 16'h00AC, 1'b1, 2'b11, 4'd3, 16'h0015, 1'b1, dummy);
        wait_idle();

        send(1'b1, 16'h8001, 1'b1, 2'b01, 4'd15, 16'hFFFF, 1'b1, dummy);
        send(1'b1, 16'h8001, 1'b1, 2'b01, 4'd5,  16'hFC00, 1'b1, dummy);
        send(1'b1, 16'h1234, 1'b0, 2'b10, 4'd4,  16'h2341, 1'b1, dummy);
        send(1'b1, 16'h00F1, 1'b1, 2'b10, 4'd6,  16'hC403, 1'b1, dummy);
        send(1'b1, 16'hF00F, 1'b0, 2'b11, 4'd8,  16'h0F00, 1'b1, dummy);
        wait_idle();

        // Backpressure: result must sit still while new commands are offered.
        bus8.out_ready = 1'b0;
        send(1'b0, 16'h003C, 1'b1, 2'b01, 4'd2, 16'h000F, 1'b1, dummy);
        for (int n = 0; n < 20 && !bus8.out_valid; n++) @(negedge clk);
        y_hold = bus8.y;
        chk("bp_y_result", {24'd0, y_hold}, 32'h0F);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            bus8.a = 8'hFF; bus8.dir = 1'b0; bus8.mode = 2'b00; bus8.amt = 3'd1;
            bus8.in_valid = 1'(n % 2 == 0);
            chk("bp_y_stable",   {24'd0, bus8.y}, {24'd0, y_hold});
            chk("bp_out_valid",  {31'd0, bus8.out_valid}, 32'd1);
            chk("bp_in_ready",   {31'd0, bus8.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, bus8.in_ready}, 32'd1);
        chk("bp_release_busy",     {31'd0, bus8.busy}, 32'd0);
        wait_idle();

        send(1'b0, 16'h0081, 1'b0, 2'b10, 4'd7, 16'h0000, 1'b0, dummy);
        repeat (2) @(negedge clk);
        chk("mid_busy", {31'd0, bus8.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_y",         {24'd0, bus8.y}, 32'h0);
        chk("mid_rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        chk("mid_rst_busy",      {31'd0, bus8.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_idle", {31'd0, bus8.busy}, 32'd0);
        send(1'b0, 16'h0001, 1'b0, 2'b00, 4'd1, 16'h0002, 1'b1, dummy);
        wait_idle();

        send(1'b0, 16'h00C3, 1'b1, 2'b00, 4'd2, 16'h0030, 1'b1, acc1);
        send(1'b0, 16'h005A, 1'b0, 2'b10, 4'd3, 16'h00D2, 1'b1, acc2);
        chk("b2b_accept_gap", acc2 - acc1, 32'd4);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

`default_nettype wire
